uart_tx_port: RTL and testbench

- Memory-mapped UART transmitter on the processor's data bus; the downstream consumer of store traffic in the I/O region.
- Processor `sw` instructions to the TXDATA address push bytes into a small FIFO.
- A serializer shifts each byte out as 8N1 on a serial pin.
- A STATUS register is readable with `lw` for software polling.

---
 rtl/uart_tx_port.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_port.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// Store-mapped 8N1 UART transmitter: FIFO-buffered bytes, STATUS polling register; Tx falls 2 clks after a push into an idle port.
// Backpressure: none on the bus; a push into a full FIFO (with no same-edge pop) is dropped and sets sticky overflow.
module uart_tx_port #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0024,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Tx,
    output logic        TxBusy
);
    localparam int          PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  DEPTH       = 5'(FIFO_DEPTH);
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [4:0]       count;
    logic [4:0]       countNext;
    logic             overflow;
    stateT            state;
    stateT            stateNext;
    logic [15:0]      baudCnt;
    logic [15:0]      baudCntNext;
    logic [2:0]       bitIdx;
    logic [2:0]       bitIdxNext;
    logic [7:0]       shiftReg;
    logic [7:0]       shiftNext;
    logic             txNext;
    logic             pop;
    logic             pushReq;
    logic             pushOk;
    logic             ovfClr;
    logic             bitEnd;
    logic             empty;
    logic             full;
    logic             unusedWriteData;

    assign empty           = (count == 5'd0);
    assign full            = (count == DEPTH);
    assign bitEnd          = (baudCnt == BIT_LAST);
    assign pushReq         = MemWrite && (Address == BASE_ADDR);
    assign ovfClr          = MemWrite && (Address == STATUS_ADDR) && WriteData[3];
    // A full FIFO still takes the byte when the serializer frees a slot on the same edge.
    assign pushOk          = pushReq && (!full || pop);
    assign unusedWriteData = ^WriteData[31:8];

    always_comb begin
        countNext = count;
        if (pushOk && !pop) begin
            countNext = count + 5'd1;
        end else if (!pushOk && pop) begin
            countNext = count - 5'd1;
        end
    end

    always_comb begin
        stateNext   = state;
        baudCntNext = bitEnd ? 16'd0 : baudCnt + 16'd1;
        bitIdxNext  = bitIdx;
        shiftNext   = shiftReg;
        pop         = 1'b0;
        txNext      = 1'b1;
        case (state)
            IDLE: begin
                baudCntNext = 16'd0;
                if (!empty) begin
                    pop       = 1'b1;
                    shiftNext = fifoMem[rdPtr];
                    stateNext = START;
                end
            end
            START: begin
                txNext = 1'b0;
                if (bitEnd) begin
                    stateNext  = DATA;
                    bitIdxNext = 3'd0;
                end
            end
            DATA: begin
                txNext = shiftReg[0];
                if (bitEnd) begin
                    shiftNext  = {1'b0, shiftReg[7:1]};
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end
                end
            end
            STOP: begin
                if (bitEnd) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shiftNext = fifoMem[rdPtr];
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baudCnt  <= 16'd0;
            bitIdx   <= 3'd0;
            shiftReg <= 8'd0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
            Tx       <= 1'b1;
            TxBusy   <= 1'b0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            count    <= countNext;
            Tx       <= txNext;
            TxBusy   <= (stateNext != IDLE) || (countNext != 5'd0);
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (pushReq && !pushOk) begin
                overflow <= 1'b1;
            end else if (ovfClr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem[wrPtr] <= WriteData[7:0];
        end
    end

    // Zero when not selected so the bus can OR this with RAM read data.
    always_comb begin
        ReadData = 32'd0;
        if (MemRead && (Address == STATUS_ADDR)) begin
            ReadData = {24'd0, count[3:0], overflow, empty, (state != IDLE), full};
        end
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: expected bytes and STATUS words are queued by stimulus, popped by monitors.
module tb_uart_tx_port;
    localparam logic [31:0] BASE   = 32'h1001_0024;
    localparam logic [31:0] STAT   = 32'h1001_0028;
    localparam int          CPB    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        Tx;
    logic        TxBusy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int startCount = 0;
    logic monOn = 1'b0;
    logic discard = 1'b0;

    logic [7:0]  expQ[$];
    logic [31:0] rdQ[$];
    string       rdNameQ[$];
    int          startQ[$];

    uart_tx_port #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
        .Tx(Tx), .TxBusy(TxBusy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Caller is at posedge+1; the write is sampled on the next edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        rdQ.push_back(exp); rdNameQ.push_back(name);
        Address = a; MemRead = 1'b1;
        @(posedge clk); #1;
        MemRead = 1'b0; Address = 32'd0;
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (MemRead === 1'b1) begin
            if (rdQ.size() == 0) begin
                chk("unexpected_read", ReadData, 32'hFFFF_FFFF);
            end else begin
                chk(rdNameQ.pop_front(), ReadData, rdQ.pop_front());
            end
        end
    end

    // Serial monitor: samples each bit at its mid-point, frame start = first low cycle.
    initial begin : serMon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (monOn && Tx === 1'b0) begin
                startQ.push_back(cyc);
                startCount++;
                repeat (2) @(negedge clk);
                if (!discard) chk("start_bit", Tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = Tx;
                end
                repeat (CPB) @(negedge clk);
                if (!discard) begin
                    chk("stop_bit", Tx, 1'b1);
                    if (expQ.size() == 0) begin
                        chk("unexpected_byte", b, 32'hFFFF_FFFF);
                    end else begin
                        chk("tx_byte", b, expQ.pop_front());
                    end
                end
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        waitClk(2);
        chk("reset_tx", Tx, 1'b1);
        chk("reset_busy", TxBusy, 1'b0);
        rd("reset_status", STAT, 32'h0000_0004);
        reset = 1'b1;
        monOn = 1'b1;
        waitClk(3);

        // Single frame 0x55: latency and busy window
        expQ.push_back(8'h55);
        wr(BASE, 32'hABCD_0055);
        chk("busy_after_push", TxBusy, 1'b1);
        waitClk(1);
        chk("tx_high_e1", Tx, 1'b1);
        waitClk(1);
        chk("tx_low_e2", Tx, 1'b0);
        waitClk(38);
        chk("busy_e40", TxBusy, 1'b1);
        waitClk(1);
        chk("busy_e41", TxBusy, 1'b0);
        waitClk(5);

        // Five back-to-back pushes: fill and gapless frames
        startQ.delete();
        for (int i = 1; i <= 5; i++) begin
            expQ.push_back(8'(i));
            wr(BASE, 32'(i));
        end
        rd("full_status", STAT, 32'h0000_0043);
        waitClk(220);
        chk("frame_count", startQ.size(), 5);
        for (int i = 1; i < startQ.size(); i++) begin
            chk("gapless", startQ[i] - startQ[i-1], 10 * CPB);
        end

        // Overflow while full and mid-DATA, then clear
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(8'h11 + 8'(i));
            wr(BASE, 32'h11 + 32'(i));
        end
        waitClk(10);
        wr(BASE, 32'h77);
        rd("overflow_set", STAT, 32'h0000_004B);
        wr(STAT, 32'h8);
        rd("overflow_clr", STAT, 32'h0000_0043);
        waitClk(220);

        // Reset in the middle of 0x3C's data bits with two bytes queued
        discard = 1'b1;
        wr(BASE, 32'h3C);
        wr(BASE, 32'hA1);
        wr(BASE, 32'hA2);
        waitClk(9);
        chk("tx_mid_frame", Tx, 1'b0);
        reset = 1'b0;
        waitClk(1);
        chk("abort_tx", Tx, 1'b1);
        chk("abort_busy", TxBusy, 1'b0);
        waitClk(1);
        reset = 1'b1;
        rd("abort_status", STAT, 32'h0000_0004);
        waitClk(60);
        discard = 1'b0;
        begin
            int sc;
            sc = startCount;
            waitClk(100);
            chk("no_frames_after_reset", startCount, sc);
        end

        // Decode: non-STATUS reads are zero, unmapped writes ignored
        rd("read_txdata", BASE, 32'd0);
        rd("read_unmapped", 32'h1001_0000, 32'd0);
        rd("read_base8", BASE + 32'd8, 32'd0);
        Address = STAT;
        #2;
        chk("status_no_memread", ReadData, 32'd0);
        Address = 32'd0;
        waitClk(1);
        wr(BASE + 32'd8, 32'h99);
        rd("unmapped_write_status", STAT, 32'h0000_0004);
        waitClk(60);

        chk("expq_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
